// File: rtl/permutation_check.sv
// permutation_check: scans a chromosome of NUM_GENES city genes, one gene per
// cycle, and reports whether the genes form a permutation of 0..NUM_GENES-1.
// The result gives the number of invalid positions and the lowest invalid position.
// Optional feature macro: GENE_REPAIR_EN. When it is defined, a second pass
// overwrites each invalid gene with the lowest unused city. When it is undefined,
// the repaired output is the latched chromosome unchanged.
module permutation_check #(
  parameter int NUM_GENES = 30,
  parameter int GENE_W    = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_GENES*GENE_W-1:0]   chromosome,
  output logic                          done,
  output logic                          valid,
  output logic [GENE_W-1:0]             bad_count,
  output logic [GENE_W-1:0]             first_bad,
  output logic [NUM_GENES*GENE_W-1:0]   repaired
);

  localparam int CHROM_W = NUM_GENES * GENE_W;
  localparam int BASE_W  = $clog2(CHROM_W);
  localparam int VAL_N   = 2 ** GENE_W;
  localparam logic [GENE_W-1:0] LAST_POS  = GENE_W'(NUM_GENES - 1);
  localparam logic [GENE_W-1:0] NUM_G     = GENE_W'(NUM_GENES);
  localparam logic [GENE_W-1:0] NONE_POS  = {GENE_W{1'b1}};

`ifdef GENE_REPAIR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, REPAIR = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t                 state_q, state_d;
  logic [GENE_W-1:0]      pos_q, pos_d;
  logic [NUM_GENES-1:0]   seen_q, seen_d;
  logic [NUM_GENES-1:0]   bad_pos_q, bad_pos_d;
  logic                   done_q, done_d;
  logic                   valid_q, valid_d;
  logic [GENE_W-1:0]      bad_count_q, bad_count_d;
  logic [GENE_W-1:0]      first_bad_q, first_bad_d;
  logic [CHROM_W-1:0]     repaired_q, repaired_d;

  logic [BASE_W-1:0]      base_s;
  logic [GENE_W-1:0]      gene_s;
  logic [VAL_N-1:0]       seen_ext_s;
  logic                   gene_bad_s;
  logic [GENE_W-1:0]      free_s;

  // Lowest city index not yet used; the caller guarantees one exists.
  function automatic logic [GENE_W-1:0] lowest_free(input logic [NUM_GENES-1:0] used);
    logic [GENE_W-1:0] idx;
    idx = {GENE_W{1'b0}};
    for (int i = NUM_GENES - 1; i >= 0; i--) begin
      if (!used[i]) begin
        idx = i[GENE_W-1:0];
      end
    end
    return idx;
  endfunction

  // The gene under the cursor is read from the latched copy. The seen mask is
  // widened so that out-of-range gene values index a zero bit.
  assign base_s     = BASE_W'(pos_q) * BASE_W'(GENE_W);
  assign gene_s     = repaired_q[base_s +: GENE_W];
  assign seen_ext_s = {{(VAL_N - NUM_GENES){1'b0}}, seen_q};
  assign gene_bad_s = (gene_s >= NUM_G) || seen_ext_s[gene_s];
  assign free_s     = lowest_free(seen_q);

  // Next-state and datapath: scan pass, optional repair pass, one-cycle done.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    seen_d      = seen_q;
    bad_pos_d   = bad_pos_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    bad_count_d = bad_count_q;
    first_bad_d = first_bad_q;
    repaired_d  = repaired_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          repaired_d  = chromosome;
          seen_d      = {NUM_GENES{1'b0}};
          bad_pos_d   = {NUM_GENES{1'b0}};
          bad_count_d = {GENE_W{1'b0}};
          first_bad_d = NONE_POS;
          valid_d     = 1'b0;
          pos_d       = {GENE_W{1'b0}};
          state_d     = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (gene_bad_s) begin
          bad_pos_d[pos_q] = 1'b1;
          bad_count_d      = bad_count_q + {{(GENE_W-1){1'b0}}, 1'b1};
          if (first_bad_q == NONE_POS) begin
            first_bad_d = pos_q;
          end else begin
            first_bad_d = first_bad_q;
          end
        end else begin
          seen_d[gene_s] = 1'b1;
        end
        if (pos_q == LAST_POS) begin
          pos_d = {GENE_W{1'b0}};
`ifdef GENE_REPAIR_EN
          if (bad_count_d != {GENE_W{1'b0}}) begin
            state_d = REPAIR;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end
`else
          state_d = DONE;
          done_d  = 1'b1;
          valid_d = (bad_count_d == {GENE_W{1'b0}});
`endif
        end else begin
          pos_d = pos_q + {{(GENE_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef GENE_REPAIR_EN
      REPAIR: begin
        if (bad_pos_q[pos_q]) begin
          repaired_d[base_s +: GENE_W] = free_s;
          seen_d[free_s]               = 1'b1;
        end else begin
          seen_d = seen_q;
        end
        if (pos_q == LAST_POS) begin
          pos_d   = {GENE_W{1'b0}};
          state_d = DONE;
          done_d  = 1'b1;
          // Validity describes the chromosome as it was received.
          valid_d = (bad_count_q == {GENE_W{1'b0}});
        end else begin
          pos_d = pos_q + {{(GENE_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      DONE: begin
        // A start seen here is dropped, not queued.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pos_q       <= {GENE_W{1'b0}};
      seen_q      <= {NUM_GENES{1'b0}};
      bad_pos_q   <= {NUM_GENES{1'b0}};
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      bad_count_q <= {GENE_W{1'b0}};
      first_bad_q <= NONE_POS;
      repaired_q  <= {CHROM_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      seen_q      <= seen_d;
      bad_pos_q   <= bad_pos_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      bad_count_q <= bad_count_d;
      first_bad_q <= first_bad_d;
      repaired_q  <= repaired_d;
    end
  end

  assign done      = done_q;
  assign valid     = valid_q;
  assign bad_count = bad_count_q;
  assign first_bad = first_bad_q;
  assign repaired  = repaired_q;

endmodule

// File: tb/tb_permutation_check.sv
// Scoreboard bench for permutation_check: stimulus pushes expected results,
// and a monitor pops one result and compares it on every done pulse.
module tb_permutation_check;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [149:0] chromosome;
  logic         done;
  logic         valid;
  logic [4:0]   bad_count;
  logic [4:0]   first_bad;
  logic [149:0] repaired;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic         v;
    logic [4:0]   bc;
    logic [4:0]   fb;
    logic [149:0] rep;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];

  permutation_check dut (
    .clk(clk), .reset(reset), .start(start), .chromosome(chromosome),
    .done(done), .valid(valid), .bad_count(bad_count), .first_bad(first_bad),
    .repaired(repaired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [149:0] act, input logic [149:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes exactly one expected entry.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid",     150'(valid),       150'(e.v));
        check("bad_count", 150'(bad_count),   150'(e.bc));
        check("first_bad", 150'(first_bad),   150'(e.fb));
        check("repaired",  repaired,          e.rep);
        check("latency",   150'(cyc - e.t0),  150'(e.lat));
      end
    end
  end

  function automatic logic [149:0] identity();
    logic [149:0] c;
    for (int i = 0; i < 30; i++) c[5*i +: 5] = 5'(i);
    return c;
  endfunction

  // Wait for done with a cycle budget; a timeout counts as a failure.
  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", limit);
    end
  endtask

  // Issue one check. rep_fix is the expected repaired value when repair is built.
  task automatic run(input logic [149:0] c, input logic v, input logic [4:0] bc,
                     input logic [4:0] fb, input logic [149:0] rep_fix,
                     input logic scramble);
    exp_t e;
    e.v  = v;
    e.bc = bc;
    e.fb = fb;
`ifdef GENE_REPAIR_EN
    e.rep = rep_fix;
    e.lat = (bc != 5'd0) ? 61 : 31;
`else
    e.rep = c;
    e.lat = 31;
`endif
    @(negedge clk);
    chromosome = c;
    start      = 1'b1;
    e.t0       = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (scramble) chromosome = ~c;
    wait_done(80);
    @(negedge clk);
  endtask

  initial begin
    logic [149:0] c;
    logic [149:0] fix;
    reset      = 1'b1;
    start      = 1'b1;
    chromosome = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_done",      150'(done),      150'(1'b0));
    check("rst_valid",     150'(valid),     150'(1'b0));
    check("rst_bad_count", 150'(bad_count), 150'(5'd0));
    check("rst_first_bad", 150'(first_bad), 150'(5'd31));
    check("rst_repaired",  repaired,        150'(0));

    // 1: identity; the input is scrambled after the latch cycle.
    c = identity();
    run(c, 1'b1, 5'd0, 5'd31, c, 1'b1);

    // 2: genes 4 and 17 exchanged.
    c = identity();
    c[5*4 +: 5]  = 5'd17;
    c[5*17 +: 5] = 5'd4;
    run(c, 1'b1, 5'd0, 5'd31, c, 1'b0);

    // 3: gene7 duplicates gene3.
    c = identity();
    c[5*7 +: 5] = 5'd3;
    run(c, 1'b0, 5'd1, 5'd7, identity(), 1'b0);

    // 4: all zero.
    c = '0;
    run(c, 1'b0, 5'd29, 5'd1, identity(), 1'b0);

    // 5: gene0 out of range, gene29 = 0.
    c = identity();
    c[5*0 +: 5]  = 5'd31;
    c[5*29 +: 5] = 5'd0;
    fix = c;
    fix[5*0 +: 5] = 5'd29;
    run(c, 1'b0, 5'd1, 5'd0, fix, 1'b0);

    // Held outputs after done: gene29 = 0 and gene0 = 31.
    repeat (5) @(negedge clk);
    check("hold_bad_count", 150'(bad_count), 150'(5'd1));
    check("hold_first_bad", 150'(first_bad), 150'(5'd0));

    // 6: reset during SCAN while start pulses; no done may follow.
    @(negedge clk);
    chromosome = '0;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      start = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_valid",     150'(valid),     150'(1'b0));
    check("abort_bad_count", 150'(bad_count), 150'(5'd0));
    check("abort_first_bad", 150'(first_bad), 150'(5'd31));
    check("abort_repaired",  repaired,        150'(0));
    repeat (70) @(negedge clk);

    // A start during the DONE cycle is dropped; the clean run follows.
    c = identity();
    c[5*2 +: 5] = 5'd30;
    fix = identity();
    begin
      exp_t e;
      e.v = 1'b0; e.bc = 5'd1; e.fb = 5'd2;
`ifdef GENE_REPAIR_EN
      e.rep = fix; e.lat = 61;
`else
      e.rep = c;   e.lat = 31;
`endif
      chromosome = c;
      start = 1'b1;
      e.t0 = cyc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_done(80);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (70) @(negedge clk);
    check("post_done_start_ignored", 150'(first_bad), 150'(5'd2));
    check("sb_empty", 150'(sb.size()), 150'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
